lut_layer_sched: RTL and testbench

- Sequences one layer of LUT neurons through a single shared truth-table memory, one neuron per cycle, instead of instantiating one distributed-ROM neuron per output.
- Latches an input activation vector and gathers each neuron's FAN_IN bits through a static connection map.
- Issues {neuron index, fan-in bits} as the memory address, then collects the 1-bit results into an output vector.
- Sits between layer N-1 output registers and layer N input registers; valid/ready on both sides.

---
 rtl/lut_layer_sched_if.sv | 30 +++
 rtl/lut_layer_sched.sv | 142 ++++++++++++++
 tb/tb_lut_layer_sched.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lut_layer_sched_if.sv
// Handshake and truth-table memory bus of the LUT layer scheduler.
// master: the scheduler block. slave: the surrounding layer registers and memory.
interface lut_layer_sched_if #(
  parameter int NUM_NEURONS = 16,
  parameter int FAN_IN      = 8,
  parameter int IN_BITS     = 64
);
  localparam int AW = $clog2(NUM_NEURONS) + FAN_IN;

  logic                   in_valid;
  logic                   in_ready;
  logic [IN_BITS-1:0]     in_vec;
  logic                   mem_req;
  logic [AW-1:0]          mem_addr;
  logic                   mem_rdata;
  logic                   out_valid;
  logic                   out_ready;
  logic [NUM_NEURONS-1:0] out_vec;
  logic                   busy;

  modport master (
    input  in_valid, in_vec, mem_rdata, out_ready,
    output in_ready, mem_req, mem_addr, out_valid, out_vec, busy
  );

  modport slave (
    output in_valid, in_vec, mem_rdata, out_ready,
    input  in_ready, mem_req, mem_addr, out_valid, out_vec, busy
  );
endinterface

// File: rtl/lut_layer_sched.sv
// One layer of LUT neurons evaluated sequentially through a shared truth-table
// memory: latch a vector, issue {neuron, gathered fan-in bits} once per cycle,
// collect the 1-bit results into out_vec and hold them until accepted.
// Optional build macro LUTSCHED_STATS_EN adds saturating vector/stall counters.
module lut_layer_sched #(
  parameter int NUM_NEURONS = 16,
  parameter int FAN_IN      = 8,
  parameter int IN_BITS     = 64,
  parameter int MEM_LAT     = 1,
  parameter logic [NUM_NEURONS*FAN_IN*$clog2(IN_BITS)-1:0] CONN_MAP = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  lut_layer_sched_if.master     bus
`ifdef LUTSCHED_STATS_EN
  ,
  output logic [31:0]           stat_vectors,
  output logic [31:0]           stat_stall
`endif
);
  localparam int IW  = $clog2(IN_BITS);
  localparam int NIW = $clog2(NUM_NEURONS);
  localparam logic [NIW-1:0] LAST_IDX = NIW'(NUM_NEURONS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t             state;
  logic [IN_BITS-1:0] vec;
  logic [NIW-1:0]     idx;
  logic [NIW-1:0]     idx_next;
  logic               tag_vld_p [MEM_LAT];
  logic [NIW-1:0]     tag_idx_p [MEM_LAT];
  logic               last_tag;

  // Pull neuron n's fan-in bits out of the activation vector; k=0 is the LSB.
  function automatic logic [FAN_IN-1:0] gather(input logic [IN_BITS-1:0] v,
                                               input logic [NIW-1:0] n);
    logic [FAN_IN-1:0] g;
    int e;
    g = '0;
    for (int k = 0; k < FAN_IN; k++) begin
      e    = (int'(n) * FAN_IN + k) * IW;
      g[k] = v[CONN_MAP[e +: IW]];
    end
    return g;
  endfunction

  assign idx_next = idx + NIW'(1);
  // The final neuron's read leaving the tag pipe marks the end of DRAIN.
  assign last_tag = tag_vld_p[MEM_LAT-1] && (tag_idx_p[MEM_LAT-1] == LAST_IDX);

  // Control FSM, address issue, tag pipe and result collection.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.mem_req   <= 1'b0;
      bus.mem_addr  <= '0;
      bus.out_vec   <= '0;
      bus.busy      <= 1'b0;
      vec           <= '0;
      idx           <= '0;
      for (int i = 0; i < MEM_LAT; i++) begin
        tag_vld_p[i] <= 1'b0;
        tag_idx_p[i] <= '0;
      end
    end else begin
      // tag stage 0 follows the address register; each stage adds one cycle
      tag_vld_p[0] <= bus.mem_req;
      tag_idx_p[0] <= idx;
      for (int i = 1; i < MEM_LAT; i++) begin
        tag_vld_p[i] <= tag_vld_p[i-1];
        tag_idx_p[i] <= tag_idx_p[i-1];
      end
      if (tag_vld_p[MEM_LAT-1]) begin
        bus.out_vec[tag_idx_p[MEM_LAT-1]] <= bus.mem_rdata;
      end

      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            // neuron 0 is issued straight from the incoming vector
            vec          <= bus.in_vec;
            bus.out_vec  <= '0;
            idx          <= '0;
            bus.mem_req  <= 1'b1;
            bus.mem_addr <= {NIW'(0), gather(bus.in_vec, NIW'(0))};
            bus.in_ready <= 1'b0;
            bus.busy     <= 1'b1;
            state        <= RUN;
          end
        end
        RUN: begin
          if (idx == LAST_IDX) begin
            bus.mem_req <= 1'b0;
            state       <= DRAIN;
          end else begin
            idx          <= idx_next;
            bus.mem_addr <= {idx_next, gather(vec, idx_next)};
          end
        end
        DRAIN: begin
          if (last_tag) begin
            bus.out_valid <= 1'b1;
            state         <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
            bus.busy      <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef LUTSCHED_STATS_EN
  // Counters stick at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] c);
    return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
  endfunction

  // Count delivered vectors and cycles the result waits on downstream.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_vectors <= '0;
      stat_stall   <= '0;
    end else if (state == DONE) begin
      if (bus.out_ready) begin
        stat_vectors <= sat_inc(stat_vectors);
      end else begin
        stat_stall <= sat_inc(stat_stall);
      end
    end
  end
`endif
endmodule

// File: tb/tb_lut_layer_sched.sv
// Bench for lut_layer_sched: instance A uses the default geometry with an
// identity connection map and a parity truth table; instance B is the small
// MEM_LAT=2 geometry with a scrambled map and a table that answers 1 only for
// neuron 2. A cycle-level model predicts every handshake/bus output.
module tb_lut_layer_sched;
  localparam int NA = 16, FA = 8, IA = 64, LA = 1, IWA = 6;
  localparam int NB = 4,  FB = 2, IB = 4,  LB = 2, IWB = 2;

  function automatic logic [NA*FA*IWA-1:0] ident_map();
    logic [NA*FA*IWA-1:0] m;
    m = '0;
    for (int e = 0; e < NA*FA; e++) m[e*IWA +: IWA] = IWA'(e % FA);
    return m;
  endfunction

  localparam logic [NA*FA*IWA-1:0] MAP_A = ident_map();
  // (n,k) -> bit: n0:{3,0} n1:{1,2} n2:{0,3} n3:{2,2}
  localparam logic [NB*FB*IWB-1:0] MAP_B =
    {2'd2, 2'd2, 2'd3, 2'd0, 2'd2, 2'd1, 2'd0, 2'd3};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lut_layer_sched_if #(.NUM_NEURONS(NA), .FAN_IN(FA), .IN_BITS(IA)) bus_a ();
  lut_layer_sched_if #(.NUM_NEURONS(NB), .FAN_IN(FB), .IN_BITS(IB)) bus_b ();

`ifdef LUTSCHED_STATS_EN
  logic [31:0] sv_a, ss_a, sv_b, ss_b;
`endif

  lut_layer_sched #(.NUM_NEURONS(NA), .FAN_IN(FA), .IN_BITS(IA),
                    .MEM_LAT(LA), .CONN_MAP(MAP_A)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a)
`ifdef LUTSCHED_STATS_EN
    , .stat_vectors(sv_a), .stat_stall(ss_a)
`endif
  );

  lut_layer_sched #(.NUM_NEURONS(NB), .FAN_IN(FB), .IN_BITS(IB),
                    .MEM_LAT(LB), .CONN_MAP(MAP_B)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b)
`ifdef LUTSCHED_STATS_EN
    , .stat_vectors(sv_b), .stat_stall(ss_b)
`endif
  );

  // Truth-table memories: A answers with junk when not addressed.
  logic b_stage;
  always @(posedge clk)
    bus_a.mem_rdata <= bus_a.mem_req ? ^bus_a.mem_addr[7:0] : 1'($urandom);
  always @(posedge clk) begin
    b_stage         <= bus_b.mem_req && (bus_b.mem_addr[3:2] == 2'd2);
    bus_b.mem_rdata <= b_stage;
  end

  // ---------------- reference model ----------------
  function automatic int nn(input int ch); return ch ? NB : NA; endfunction
  function automatic int ll(input int ch); return ch ? LB : LA; endfunction
  function automatic int ff(input int ch); return ch ? FB : FA; endfunction

  function automatic int map_of(input int ch, input int n, input int k);
    int mb [4][2];
    mb = '{'{3, 0}, '{1, 2}, '{0, 3}, '{2, 2}};
    return ch ? mb[n][k] : k;
  endfunction

  function automatic logic [63:0] gath(input int ch, input int n, input logic [63:0] v);
    logic [63:0] g;
    g = '0;
    for (int k = 0; k < ff(ch); k++) g[k] = v[map_of(ch, n, k)];
    return g;
  endfunction

  function automatic logic [15:0] exp_out(input int ch, input logic [63:0] v);
    logic [15:0] r;
    logic [63:0] g;
    r = '0;
    for (int n = 0; n < nn(ch); n++) begin
      g = gath(ch, n, v);
      r[n] = ch ? (n == 2) : ^g[7:0];
    end
    return r;
  endfunction

  int          checks = 0;
  int          failures = 0;
  int          phase = 0;
  int          cycle = 0;
  int          m_st [2];
  int          m_c [2];
  logic [63:0] m_vec [2];
  logic [15:0] m_out [2];
  bit          m_fresh [2];
  bit          m_valid = 0;
  int          m_vecs = 0, m_stall = 0;
  bit          prev_ov [2];
  int          last_acc [2];
  int          seq_b = 0;
  bit          pend = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cycle);
    end
  endtask

  // Compare DUT outputs with the model, then advance the model across the next edge.
  initial begin
    last_acc[0] = -1;
    last_acc[1] = -1;
    for (int ch = 0; ch < 2; ch++) begin
      m_st[ch] = 0; m_c[ch] = 0; m_vec[ch] = '0; m_out[ch] = '0;
      m_fresh[ch] = 1; prev_ov[ch] = 0;
    end
    forever begin
      @(negedge clk);
      cycle++;
      for (int ch = 0; ch < 2; ch++) begin
        logic ir, bz, ov, rq, iv, ordy, exp_rq;
        logic [63:0] ad, ivec;
        logic [15:0] ovv;
        string p;
        p = ch ? "B_" : "A_";
        if (ch == 0) begin
          ir = bus_a.in_ready; bz = bus_a.busy; ov = bus_a.out_valid; rq = bus_a.mem_req;
          ad = 64'(bus_a.mem_addr); ovv = bus_a.out_vec; iv = bus_a.in_valid;
          ordy = bus_a.out_ready; ivec = bus_a.in_vec;
        end else begin
          ir = bus_b.in_ready; bz = bus_b.busy; ov = bus_b.out_valid; rq = bus_b.mem_req;
          ad = 64'(bus_b.mem_addr); ovv = 16'(bus_b.out_vec); iv = bus_b.in_valid;
          ordy = bus_b.out_ready; ivec = 64'(bus_b.in_vec);
        end
        if (m_valid) begin
          exp_rq = (m_st[ch] == 1) && (m_c[ch] <= nn(ch));
          chk({p, "in_ready"},  64'(ir), 64'(m_st[ch] == 0));
          chk({p, "busy"},      64'(bz), 64'(m_st[ch] != 0));
          chk({p, "out_valid"}, 64'(ov), 64'(m_st[ch] == 2));
          chk({p, "mem_req"},   64'(rq), 64'(exp_rq));
          if (exp_rq)
            chk({p, "mem_addr"}, ad,
                (64'(m_c[ch] - 1) << ff(ch)) | gath(ch, m_c[ch] - 1, m_vec[ch]));
          if (m_st[ch] != 1) chk({p, "out_vec"}, 64'(ovv), 64'(m_out[ch]));
          if (m_st[ch] == 0 && m_fresh[ch]) chk({p, "mem_addr_rst"}, ad, 64'd0);
          // hand-computed pins
          if (ov && !prev_ov[ch]) begin
            chk({p, "latency"}, 64'(m_c[ch]), ch ? 64'd7 : 64'd18);
            if (ch == 0 && phase == 1) begin
              chk("A_basic_out", 64'(ovv), 64'h0000);
              chk("A_basic_model", 64'(exp_out(0, 64'hFF)), 64'h0000);
            end
            if (ch == 0 && phase == 2) begin
              chk("A_odd_out", 64'(ovv), 64'hFFFF);
              chk("A_odd_model", 64'(exp_out(0, 64'h07)), 64'hFFFF);
            end
            if (ch == 0 && phase == 5) chk("A_after_abort_out", 64'(ovv), 64'hFFFF);
            if (ch == 1 && phase == 3) begin
              chk("B_order_out", 64'(ovv), 64'h4);
              chk("B_order_model", 64'(exp_out(1, 64'hA)), 64'h4);
            end
          end
          if (phase == 1 && ch == 0 && rq) chk("A_addr_low_byte", 64'(ad[7:0]), 64'hFF);
          if (phase == 3 && ch == 1 && rq) begin
            chk("B_idx_seq", 64'(ad[3:2]), 64'(seq_b));
            seq_b++;
          end
          if (phase == 6 && ir && iv) begin
            if (last_acc[ch] >= 0)
              chk({p, "b2b_interval"}, 64'(cycle - last_acc[ch]), ch ? 64'd8 : 64'd19);
            last_acc[ch] = cycle;
          end
          prev_ov[ch] = ov;
        end
        // advance model
        if (rst) begin
          m_st[ch] = 0; m_c[ch] = 0; m_out[ch] = '0; m_fresh[ch] = 1;
          if (ch == 0) begin m_vecs = 0; m_stall = 0; end
        end else begin
          case (m_st[ch])
            0: if (iv) begin
                 m_st[ch] = 1; m_c[ch] = 1; m_vec[ch] = ivec; m_out[ch] = '0; m_fresh[ch] = 0;
               end
            1: begin
                 m_c[ch]++;
                 if (m_c[ch] == nn(ch) + ll(ch) + 1) begin
                   m_st[ch] = 2;
                   m_out[ch] = exp_out(ch, m_vec[ch]);
                 end
               end
            default: begin
                 if (ordy) begin
                   m_st[ch] = 0;
                   if (ch == 0) m_vecs++;
                 end else if (ch == 0) begin
                   m_stall++;
                 end
               end
          endcase
        end
      end
`ifdef LUTSCHED_STATS_EN
      if (m_valid) begin
        chk("A_stat_vectors", 64'(sv_a), 64'(m_vecs));
        chk("A_stat_stall", 64'(ss_a), 64'(m_stall));
        if (pend) begin
          chk("A_stat_vectors_lit", 64'(sv_a), 64'd1);
          pend = 0;
        end
        if (phase == 4 && bus_a.out_valid && bus_a.out_ready) begin
          chk("A_stat_stall_lit", 64'(ss_a), 64'd10);
          chk("A_stat_vectors_pre", 64'(sv_a), 64'd0);
          pend = 1;
        end
      end
`endif
      if (rst) m_valid = 1;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    rst = 1'b1;
    bus_a.in_valid = 1'b0; bus_a.in_vec = '0; bus_a.out_ready = 1'b1;
    bus_b.in_valid = 1'b0; bus_b.in_vec = '0; bus_b.out_ready = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(2);

    // basic: all eight gathered bits set -> even parity everywhere
    phase = 1;
    bus_a.in_vec = 64'hFF; bus_a.in_valid = 1'b1;
    cyc(1);
    bus_a.in_valid = 1'b0; bus_a.in_vec = 64'hDEAD_BEEF_0000_1200;
    cyc(24);

    // odd parity -> every neuron fires
    phase = 2;
    bus_a.in_vec = 64'h07; bus_a.in_valid = 1'b1;
    cyc(1);
    bus_a.in_valid = 1'b0; bus_a.in_vec = 64'hFFFF_FFFF_FFFF_FFF8;
    cyc(24);

    // ordering on the small geometry
    phase = 3;
    bus_b.in_vec = 4'b1010; bus_b.in_valid = 1'b1;
    cyc(1);
    bus_b.in_valid = 1'b0; bus_b.in_vec = 4'b0101;
    cyc(12);

    // backpressure: ten stalled DONE cycles, a second vector offered meanwhile
    phase = 4;
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    bus_a.out_ready = 1'b0;
    bus_a.in_vec = 64'h0F; bus_a.in_valid = 1'b1;
    cyc(1);
    bus_a.in_valid = 1'b0;
    cyc(20);
    bus_a.in_vec = 64'h03; bus_a.in_valid = 1'b1;
    cyc(3);
    bus_a.in_valid = 1'b0;
    cyc(4);
    bus_a.out_ready = 1'b1;
    cyc(4);

    // reset while neuron 5 is on the bus, then a fresh vector
    phase = 5;
    bus_a.in_vec = 64'h01; bus_a.in_valid = 1'b1;
    cyc(1);
    bus_a.in_valid = 1'b0;
    cyc(5);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    cyc(3);
    bus_a.in_vec = 64'h0B; bus_a.in_valid = 1'b1;
    cyc(1);
    bus_a.in_valid = 1'b0;
    cyc(24);

    // back-to-back with the input bus changing every cycle
    phase = 6;
    bus_a.in_valid = 1'b1; bus_b.in_valid = 1'b1;
    for (int i = 0; i < 80; i++) begin
      bus_a.in_vec = {$urandom, $urandom};
      bus_b.in_vec = 4'($urandom);
      cyc(1);
    end
    bus_a.in_valid = 1'b0; bus_b.in_valid = 1'b0;
    cyc(25);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
